// File: rtl/fdc_drive_ctrl_if.sv
// fdc_drive_ctrl_if: CoCo CPU-side bus of the floppy front-end.
// The master drives the register strobes and data; the slave returns readback and CPU control.
interface fdc_drive_ctrl_if;
    logic [7:0] CPU_DATA_IN;
    logic [1:0] CPU_ADDR;
    logic       CTRL_WR;
    logic [7:0] CTRL_RD_VALUE;
    logic       FDC_RD_REQ;
    logic       FDC_WR_REQ;
    logic       HALT;
    logic       NMI;

    modport master (
        output CPU_DATA_IN, CPU_ADDR, CTRL_WR, FDC_RD_REQ, FDC_WR_REQ,
        input  CTRL_RD_VALUE, HALT, NMI
    );

    modport slave (
        input  CPU_DATA_IN, CPU_ADDR, CTRL_WR, FDC_RD_REQ, FDC_WR_REQ,
        output CTRL_RD_VALUE, HALT, NMI
    );
endinterface

// File: rtl/fdc_drive_ctrl.sv
// fdc_drive_ctrl: CoCo bus front-end for one wd1793 serving NUM_DRIVES drives.
// Define FDC_MOTOR_TIMEOUT_EN to build the motor auto-stop counter; otherwise motor_on follows the register.
module fdc_drive_ctrl #(
    parameter int NUM_DRIVES = 3,
    parameter int CE_DIV     = 6,
    parameter int MOTOR_TO   = 16666666
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    fdc_drive_ctrl_if.slave       cpu,
    output logic                  fdc_ce,
    output logic                  fdc_rd,
    output logic                  fdc_wr,
    output logic [1:0]            fdc_addr,
    output logic [7:0]            fdc_din,
    input  logic                  fdc_drq,
    input  logic                  fdc_intrq,
    output logic [1:0]            drive_index,
    output logic                  motor_on,
    input  logic [NUM_DRIVES-1:0] img_mounted,
    input  logic                  img_readonly,
    input  logic [63:0]           img_size,
    output logic                  sel_wp,
    output logic                  sel_ready,
    output logic                  sel_ds,
    output logic                  sel_side,
    output logic [19:0]           sel_size,
    input  logic                  fdc_sd_rd,
    input  logic                  fdc_sd_wr,
    output logic                  fdc_sd_ack,
    output logic [NUM_DRIVES-1:0] sd_rd,
    output logic [NUM_DRIVES-1:0] sd_wr,
    input  logic [NUM_DRIVES-1:0] sd_ack
);

    typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

    state_t          state_q, state_d;
    logic            launch;
    logic [5:0]      ce_cnt_q;
    logic [7:0]      ctrl_q;
    logic [1:0]      sel;
    logic [1:0]      rd_sync_q, wr_sync_q;
    logic            rd_edge, wr_edge;
    logic            pend_v_q, pend_wr_q, op_wr_q;
    logic [1:0]      pend_addr_q, fdc_addr_q;
    logic [7:0]      pend_din_q, fdc_din_q;
    logic [NUM_DRIVES-1:0] mnt_q, mnt_fall, wp_q, ds_q, ready_q;
    logic [19:0]     size_q [NUM_DRIVES];
    logic [19:0]     size_x [4];
    logic [3:0]      wp_x, ds_x, ready_x, ack_x;
    logic            img_ds;
    logic            sd_rd_prev_q, sd_wr_prev_q, sd_rise;
    logic            lock_q, ack_prev_q, lock_ack, ack_fall;
    logic [1:0]      lock_sel_q;

    // Clock-enable divider for the wd1793 core
    assign fdc_ce = ce_cnt_q == 6'(CE_DIV - 1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) ce_cnt_q <= '0;
        else          ce_cnt_q <= fdc_ce ? '0 : ce_cnt_q + 6'd1;
    end

    // Control register; a pending INTRQ always wins over a write to halt_en
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ctrl_q <= '0;
        end else begin
            if (cpu.CTRL_WR) ctrl_q <= cpu.CPU_DATA_IN;
            if (fdc_intrq)   ctrl_q[7] <= 1'b0;
        end
    end

    assign cpu.CTRL_RD_VALUE = ctrl_q;
    assign cpu.HALT          = ctrl_q[7] & ~fdc_drq;
    assign cpu.NMI           = ctrl_q[5] & fdc_intrq;

    always_comb begin
        drive_index = ctrl_q[0] ? 2'd1 : ctrl_q[1] ? 2'd2 : ctrl_q[2] ? 2'd3 : 2'd0;
        if (int'(drive_index) > NUM_DRIVES) drive_index = 2'd0;
    end

    assign sel = (drive_index == 2'd0) ? 2'd0 : drive_index - 2'd1;

    // CPU strobes are asynchronous; edges are taken on the first synchronizer flop
    assign rd_edge = rd_sync_q[0] & ~rd_sync_q[1];
    assign wr_edge = wr_sync_q[0] & ~wr_sync_q[1];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_v_q) begin
                    state_d = ARMED;
                    launch  = 1'b1;
                end
            end
            ARMED:   state_d = fdc_ce ? HOLD : ARMED;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_sync_q   <= '0;
            wr_sync_q   <= '0;
            pend_v_q    <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_din_q  <= '0;
            op_wr_q     <= 1'b0;
            fdc_addr_q  <= '0;
            fdc_din_q   <= '0;
        end else begin
            rd_sync_q <= {rd_sync_q[0], cpu.FDC_RD_REQ};
            wr_sync_q <= {wr_sync_q[0], cpu.FDC_WR_REQ};
            if (launch) begin
                op_wr_q    <= pend_wr_q;
                fdc_addr_q <= pend_addr_q;
                fdc_din_q  <= pend_din_q;
            end
            // A fresh edge refills the slot even in the cycle the old one launches
            if (rd_edge | wr_edge) begin
                pend_v_q    <= 1'b1;
                pend_wr_q   <= wr_edge;
                pend_addr_q <= cpu.CPU_ADDR;
                pend_din_q  <= cpu.CPU_DATA_IN;
            end else if (launch) begin
                pend_v_q <= 1'b0;
            end
        end
    end

    assign fdc_rd   = (state_q != IDLE) & ~op_wr_q;
    assign fdc_wr   = (state_q != IDLE) & op_wr_q;
    assign fdc_addr = fdc_addr_q;
    assign fdc_din  = fdc_din_q;

    // Per-drive mount metadata, captured when the mount strobe falls
    assign mnt_fall = mnt_q & ~img_mounted;
    assign img_ds   = (img_size > 64'd368600) && (img_size < 64'd740000);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mnt_q   <= '0;
            wp_q    <= '1;
            ds_q    <= '0;
            ready_q <= '0;
            for (int i = 0; i < NUM_DRIVES; i++) size_q[i] <= '0;
        end else begin
            mnt_q <= img_mounted;
            for (int i = 0; i < NUM_DRIVES; i++) begin
                if (mnt_fall[i]) begin
                    wp_q[i]    <= img_readonly;
                    ds_q[i]    <= img_ds;
                    ready_q[i] <= 1'b1;
                    size_q[i]  <= img_size[19:0];
                end
            end
        end
    end

    assign wp_x    = 4'(wp_q);
    assign ds_x    = 4'(ds_q);
    assign ready_x = 4'(ready_q);
    assign ack_x   = 4'(sd_ack);

    for (genvar g = 0; g < 4; g++) begin : g_size
        if (g < NUM_DRIVES) begin : g_real
            assign size_x[g] = size_q[g];
        end else begin : g_pad
            assign size_x[g] = '0;
        end
    end

    assign sel_wp   = wp_x[sel];
    assign sel_ds   = ds_x[sel];
    assign sel_size = size_x[sel];
    assign sel_side = sel_ds & ctrl_q[6];

`ifdef FDC_MOTOR_TIMEOUT_EN
    logic [24:0] mcnt_q;
    logic        motor_q;

    // Register writes dominate; an FDC access keeps a running motor alive
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            motor_q <= 1'b0;
            mcnt_q  <= '0;
        end else if (cpu.CTRL_WR && cpu.CPU_DATA_IN[3]) begin
            motor_q <= 1'b1;
            mcnt_q  <= 25'(MOTOR_TO);
        end else if (cpu.CTRL_WR) begin
            motor_q <= 1'b0;
        end else if (launch && motor_q) begin
            mcnt_q <= 25'(MOTOR_TO);
        end else if (fdc_ce && motor_q) begin
            mcnt_q <= mcnt_q - 25'd1;
            if (mcnt_q == 25'd1) motor_q <= 1'b0;
        end
    end

    assign motor_on  = motor_q;
    assign sel_ready = ready_x[sel] & motor_q;
`else
    assign motor_on  = ctrl_q[3];
    assign sel_ready = ready_x[sel];
`endif

    // SD routing: the drive is frozen for a whole transfer, released by its ack falling
    assign sd_rise  = (fdc_sd_rd & ~sd_rd_prev_q) | (fdc_sd_wr & ~sd_wr_prev_q);
    assign lock_ack = ack_x[lock_sel_q];
    assign ack_fall = lock_q & ack_prev_q & ~lock_ack;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sd_rd_prev_q <= 1'b0;
            sd_wr_prev_q <= 1'b0;
            ack_prev_q   <= 1'b0;
            lock_q       <= 1'b0;
            lock_sel_q   <= '0;
        end else begin
            sd_rd_prev_q <= fdc_sd_rd;
            sd_wr_prev_q <= fdc_sd_wr;
            ack_prev_q   <= lock_q & lock_ack;
            if (ack_fall) begin
                lock_q <= 1'b0;
            end else if (!lock_q && sd_rise && drive_index != 2'd0) begin
                lock_q     <= 1'b1;
                lock_sel_q <= sel;
            end
        end
    end

    for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_sd
        assign sd_rd[g] = lock_q & fdc_sd_rd & (lock_sel_q == 2'(g));
        assign sd_wr[g] = lock_q & fdc_sd_wr & (lock_sel_q == 2'(g));
    end

    assign fdc_sd_ack = lock_q & lock_ack;

endmodule

// File: tb/tb_fdc_drive_ctrl.sv
// tb_fdc_drive_ctrl: vector table, randomized register/mount traffic against a reference model,
// and directed sequences for access strobes, SD locking, motor timing and reset.
module tb_fdc_drive_ctrl;

    logic CLK = 1'b0;
    logic RESET_N;
    always #5 CLK = ~CLK;

    fdc_drive_ctrl_if bus ();
    fdc_drive_ctrl_if bus2 ();

    logic        fdc_ce, fdc_rd, fdc_wr, fdc_drq, fdc_intrq;
    logic [1:0]  fdc_addr, drive_index;
    logic [7:0]  fdc_din;
    logic        motor_on, img_readonly;
    logic [2:0]  img_mounted, sd_rd, sd_wr, sd_ack;
    logic [63:0] img_size;
    logic        sel_wp, sel_ready, sel_ds, sel_side;
    logic [19:0] sel_size;
    logic        fdc_sd_rd, fdc_sd_wr, fdc_sd_ack;

    logic        d2_ce, d2_rd, d2_wr, d2_motor, d2_wp, d2_ready, d2_ds, d2_side;
    logic [1:0]  d2_addr, d2_idx, d2_sd_rd, d2_sd_wr, d2_sd_ack;
    logic [7:0]  d2_din;
    logic [19:0] d2_size;
    logic        d2_fdc_sd_rd, d2_fdc_sd_ack;

    fdc_drive_ctrl #(.NUM_DRIVES(3), .CE_DIV(4), .MOTOR_TO(10)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .cpu(bus),
        .fdc_ce(fdc_ce), .fdc_rd(fdc_rd), .fdc_wr(fdc_wr), .fdc_addr(fdc_addr), .fdc_din(fdc_din),
        .fdc_drq(fdc_drq), .fdc_intrq(fdc_intrq), .drive_index(drive_index), .motor_on(motor_on),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
        .sel_wp(sel_wp), .sel_ready(sel_ready), .sel_ds(sel_ds), .sel_side(sel_side), .sel_size(sel_size),
        .fdc_sd_rd(fdc_sd_rd), .fdc_sd_wr(fdc_sd_wr), .fdc_sd_ack(fdc_sd_ack),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack)
    );

    fdc_drive_ctrl #(.NUM_DRIVES(2), .CE_DIV(4), .MOTOR_TO(10)) u_dut2 (
        .CLK(CLK), .RESET_N(RESET_N), .cpu(bus2),
        .fdc_ce(d2_ce), .fdc_rd(d2_rd), .fdc_wr(d2_wr), .fdc_addr(d2_addr), .fdc_din(d2_din),
        .fdc_drq(1'b0), .fdc_intrq(1'b0), .drive_index(d2_idx), .motor_on(d2_motor),
        .img_mounted(2'b00), .img_readonly(1'b0), .img_size(64'd0),
        .sel_wp(d2_wp), .sel_ready(d2_ready), .sel_ds(d2_ds), .sel_side(d2_side), .sel_size(d2_size),
        .fdc_sd_rd(d2_fdc_sd_rd), .fdc_sd_wr(1'b0), .fdc_sd_ack(d2_fdc_sd_ack),
        .sd_rd(d2_sd_rd), .sd_wr(d2_sd_wr), .sd_ack(d2_sd_ack)
    );

    typedef struct {
        logic [7:0] wv;
        logic       intrq;
        logic       drq;
        logic [1:0] idx;
        logic [7:0] rdv;
        logic       halt;
        logic       nmi;
    } vec_t;

    vec_t        tv [7];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mctrl;
    logic        m_wp [3];
    logic        m_ds [3];
    logic        m_ready [3];
    logic [19:0] m_size [3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] f_idx(input logic [7:0] v, input int n);
        for (int i = 0; i < 3; i++)
            if (v[i]) return (i + 1 <= n) ? 2'(i + 1) : 2'd0;
        return 2'd0;
    endfunction

    function automatic int f_sel(input logic [7:0] v);
        return (f_idx(v, 3) == 2'd0) ? 0 : int'(f_idx(v, 3)) - 1;
    endfunction

    function automatic logic [63:0] pick_size();
        case ($urandom_range(0, 6))
            0:       return 64'd368600;
            1:       return 64'd368601;
            2:       return 64'd368640;
            3:       return 64'd739999;
            4:       return 64'd740000;
            5:       return {32'd1, 32'd368640};
            default: return 64'($urandom_range(0, 1048575));
        endcase
    endfunction

    task automatic ctrl_wr(input logic [7:0] v);
        @(negedge CLK);
        bus.CPU_DATA_IN = v;
        bus.CTRL_WR = 1'b1;
        @(negedge CLK);
        bus.CTRL_WR = 1'b0;
        mctrl = fdc_intrq ? {1'b0, v[6:0]} : v;
    endtask

    task automatic mount(input int d, input logic [63:0] sz, input logic ro);
        @(negedge CLK);
        img_size = sz;
        img_readonly = ro;
        img_mounted[d] = 1'b1;
        @(negedge CLK);
        img_mounted[d] = 1'b0;
        @(negedge CLK);
        m_wp[d] = ro;
        m_size[d] = sz[19:0];
        m_ready[d] = 1'b1;
        m_ds[d] = (sz > 64'd368600) && (sz < 64'd740000);
    endtask

    task automatic chk_sel();
        int s;
        s = f_sel(mctrl);
        chk("sel_wp", sel_wp, m_wp[s]);
        chk("sel_ds", sel_ds, m_ds[s]);
        chk("sel_size", sel_size, m_size[s]);
        chk("sel_side", sel_side, m_ds[s] & mctrl[6]);
    endtask

    task automatic wait_strobe(input bit want_wr, input logic [1:0] ea, input logic [7:0] ed, input string nm);
        int g;
        int ces;
        g = 0;
        while (!(want_wr ? fdc_wr : fdc_rd) && g < 30) begin
            @(negedge CLK);
            g++;
        end
        chk({nm, " strobe seen"}, want_wr ? fdc_wr : fdc_rd, 1'b1);
        chk({nm, " other strobe"}, want_wr ? fdc_rd : fdc_wr, 1'b0);
        chk({nm, " fdc_addr"}, fdc_addr, ea);
        chk({nm, " fdc_din"}, fdc_din, ed);
        ces = 0;
        g = 0;
        while ((want_wr ? fdc_wr : fdc_rd) && g < 30) begin
            ces += int'(fdc_ce);
            @(negedge CLK);
            g++;
        end
        chk({nm, " ce overlap"}, ces, 1);
    endtask

    initial begin
        int cnt;
        int g;
        int rd_seen;
        logic [7:0] v;

        tv[0] = '{8'h8A, 1'b0, 1'b0, 2'd2, 8'h8A, 1'b1, 1'b0};
        tv[1] = '{8'h8A, 1'b0, 1'b1, 2'd2, 8'h8A, 1'b0, 1'b0};
        tv[2] = '{8'h07, 1'b0, 1'b0, 2'd1, 8'h07, 1'b0, 1'b0};
        tv[3] = '{8'hA4, 1'b1, 1'b0, 2'd3, 8'h24, 1'b0, 1'b1};
        tv[4] = '{8'h20, 1'b0, 1'b0, 2'd0, 8'h20, 1'b0, 1'b0};
        tv[5] = '{8'hC6, 1'b0, 1'b0, 2'd2, 8'hC6, 1'b1, 1'b0};
        tv[6] = '{8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};

        RESET_N = 1'b0;
        bus.CPU_DATA_IN = '0; bus.CPU_ADDR = '0; bus.CTRL_WR = 1'b0;
        bus.FDC_RD_REQ = 1'b0; bus.FDC_WR_REQ = 1'b0;
        bus2.CPU_DATA_IN = '0; bus2.CPU_ADDR = '0; bus2.CTRL_WR = 1'b0;
        bus2.FDC_RD_REQ = 1'b0; bus2.FDC_WR_REQ = 1'b0;
        fdc_drq = 1'b0; fdc_intrq = 1'b0;
        img_mounted = '0; img_readonly = 1'b0; img_size = '0;
        fdc_sd_rd = 1'b0; fdc_sd_wr = 1'b0; sd_ack = '0;
        d2_fdc_sd_rd = 1'b0; d2_sd_ack = '0;
        mctrl = '0;
        for (int i = 0; i < 3; i++) begin
            m_wp[i] = 1'b1; m_ds[i] = 1'b0; m_ready[i] = 1'b0; m_size[i] = '0;
        end
        repeat (3) @(negedge CLK);
        chk("rst CTRL_RD_VALUE", bus.CTRL_RD_VALUE, 8'h00);
        chk("rst drive_index", drive_index, 2'd0);
        chk("rst HALT", bus.HALT, 1'b0);
        chk("rst NMI", bus.NMI, 1'b0);
        chk("rst motor_on", motor_on, 1'b0);
        chk("rst sel_ready", sel_ready, 1'b0);
        chk("rst sel_wp", sel_wp, 1'b1);
        chk("rst strobes", {fdc_rd, fdc_wr}, 2'b00);
        RESET_N = 1'b1;

        // Test-plan opening sequence
        ctrl_wr(8'h8A);
        chk("8A drive_index", drive_index, 2'd2);
        chk("8A motor_on", motor_on, 1'b1);
        chk("8A HALT", bus.HALT, 1'b1);
        chk("8A rdback", bus.CTRL_RD_VALUE, 8'h8A);
        fdc_intrq = 1'b1;
        @(negedge CLK);
        fdc_intrq = 1'b0;
        mctrl[7] = 1'b0;
        @(negedge CLK);
        chk("intrq HALT", bus.HALT, 1'b0);
        chk("intrq rdback", bus.CTRL_RD_VALUE, 8'h0A);

        for (int i = 0; i < 7; i++) begin
            fdc_intrq = tv[i].intrq;
            fdc_drq = tv[i].drq;
            ctrl_wr(tv[i].wv);
            chk("tbl drive_index", drive_index, tv[i].idx);
            chk("tbl rdback", bus.CTRL_RD_VALUE, tv[i].rdv);
            chk("tbl HALT", bus.HALT, tv[i].halt);
            chk("tbl NMI", bus.NMI, tv[i].nmi);
        end
        fdc_intrq = 1'b0;
        fdc_drq = 1'b0;

        // Directed mount: 368640-byte read-only image on drive 2
        mount(1, 64'd368640, 1'b1);
        ctrl_wr(8'h4A);
        chk("mnt sel_ds", sel_ds, 1'b1);
        chk("mnt sel_side", sel_side, 1'b1);
        chk("mnt sel_wp", sel_wp, 1'b1);
        chk("mnt sel_size", sel_size, 20'd368640);
        chk("mnt sel_ready", sel_ready, 1'b1);

        // Randomized register writes and mounts against the model
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                mount(int'($urandom_range(0, 2)), pick_size(), 1'($urandom_range(0, 1)));
            end else begin
                fdc_drq = 1'($urandom_range(0, 1));
                v = 8'($urandom_range(0, 255));
                ctrl_wr(v);
                chk("rnd drive_index", drive_index, f_idx(v, 3));
                chk("rnd rdback", bus.CTRL_RD_VALUE, mctrl);
                chk("rnd HALT", bus.HALT, mctrl[7] & ~fdc_drq);
                chk("rnd motor_on", motor_on, v[3]);
`ifdef FDC_MOTOR_TIMEOUT_EN
                chk("rnd sel_ready", sel_ready, m_ready[f_sel(v)] & v[3]);
`else
                chk("rnd sel_ready", sel_ready, m_ready[f_sel(v)]);
`endif
            end
            chk_sel();
        end
        fdc_drq = 1'b0;

        // Write request, read request two cycles later
        @(negedge CLK);
        bus.CPU_ADDR = 2'd3; bus.CPU_DATA_IN = 8'h5A; bus.FDC_WR_REQ = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        bus.CPU_ADDR = 2'd1; bus.CPU_DATA_IN = 8'h11; bus.FDC_RD_REQ = 1'b1;
        wait_strobe(1'b1, 2'd3, 8'h5A, "wr");
        wait_strobe(1'b0, 2'd1, 8'h11, "rd");
        bus.FDC_WR_REQ = 1'b0; bus.FDC_RD_REQ = 1'b0;
        repeat (4) @(negedge CLK);

        // Simultaneous edges: write wins, no read follows
        bus.CPU_ADDR = 2'd2; bus.CPU_DATA_IN = 8'hC3;
        bus.FDC_WR_REQ = 1'b1; bus.FDC_RD_REQ = 1'b1;
        wait_strobe(1'b1, 2'd2, 8'hC3, "both");
        rd_seen = 0;
        repeat (12) begin
            rd_seen += int'(fdc_rd);
            @(negedge CLK);
        end
        chk("both no read", rd_seen, 0);
        bus.FDC_WR_REQ = 1'b0; bus.FDC_RD_REQ = 1'b0;
        repeat (4) @(negedge CLK);

        // SD lock survives a drive change until the locked ack falls
        ctrl_wr(8'h09);
        fdc_sd_rd = 1'b1;
        @(negedge CLK);
        chk("sd lock d1", sd_rd, 3'b001);
        ctrl_wr(8'h0A);
        chk("sd held d1", sd_rd, 3'b001);
        sd_ack = 3'b001;
        @(negedge CLK);
        chk("sd ack d1", fdc_sd_ack, 1'b1);
        sd_ack = 3'b000;
        @(negedge CLK);
        chk("sd unlocked", sd_rd, 3'b000);
        fdc_sd_rd = 1'b0;
        @(negedge CLK);
        fdc_sd_wr = 1'b1;
        @(negedge CLK);
        chk("sd wr d2", {sd_rd, sd_wr}, {3'b000, 3'b010});
        sd_ack = 3'b011;
        @(negedge CLK);
        chk("sd ack d2", fdc_sd_ack, 1'b1);
        sd_ack = 3'b001;
        @(negedge CLK);
        chk("sd d2 released", sd_wr, 3'b000);
        fdc_sd_wr = 1'b0; sd_ack = 3'b000;

        // Two-drive instance: select bit 2 is out of range
        @(negedge CLK);
        bus2.CPU_DATA_IN = 8'h04; bus2.CTRL_WR = 1'b1;
        @(negedge CLK);
        bus2.CTRL_WR = 1'b0;
        chk("d2 idx 04", d2_idx, f_idx(8'h04, 2));
        d2_fdc_sd_rd = 1'b1; d2_sd_ack = 2'b11;
        repeat (2) @(negedge CLK);
        chk("d2 no fwd", {d2_sd_rd, d2_sd_wr}, 4'b0000);
        chk("d2 no ack", d2_fdc_sd_ack, 1'b0);
        d2_fdc_sd_rd = 1'b0; d2_sd_ack = 2'b00;
        bus2.CPU_DATA_IN = 8'h02; bus2.CTRL_WR = 1'b1;
        @(negedge CLK);
        bus2.CTRL_WR = 1'b0;
        chk("d2 idx 02", d2_idx, f_idx(8'h02, 2));

`ifdef FDC_MOTOR_TIMEOUT_EN
        ctrl_wr(8'h08);
        cnt = 0; g = 0;
        while (motor_on && g < 200) begin
            cnt += int'(fdc_ce);
            @(negedge CLK);
            g++;
        end
        chk("motor pulses", cnt, 10);
        ctrl_wr(8'h08);
        cnt = 0; g = 0;
        while (cnt < 9 && g < 200) begin
            if (fdc_ce) cnt++;
            if (cnt < 9) @(negedge CLK);
            g++;
        end
        bus.CPU_ADDR = 2'd0; bus.FDC_WR_REQ = 1'b1;
        g = 0;
        while (!fdc_wr && g < 30) begin
            @(negedge CLK);
            g++;
        end
        chk("reload strobe", fdc_wr, 1'b1);
        chk("reload motor on", motor_on, 1'b1);
        bus.FDC_WR_REQ = 1'b0;
        cnt = 0; g = 0;
        while (motor_on && g < 200) begin
            cnt += int'(fdc_ce);
            @(negedge CLK);
            g++;
        end
        chk("motor after reload", cnt, 10);
`else
        cnt = 0; g = 0;
        ctrl_wr(8'h08);
        repeat (60) @(negedge CLK);
        chk("motor held", motor_on, 1'b1);
        ctrl_wr(8'h00);
        chk("motor off", motor_on, 1'b0);
`endif
        repeat (4) @(negedge CLK);

        // Asynchronous reset in the middle of an access
        mount(0, 64'd184320, 1'b0);
        bus.CPU_ADDR = 2'd1; bus.FDC_WR_REQ = 1'b1;
        g = 0;
        while (!fdc_wr && g < 30) begin
            @(negedge CLK);
            g++;
        end
        chk("pre-reset strobe", fdc_wr, 1'b1);
        #2 RESET_N = 1'b0;
        #1;
        chk("async strobe drop", fdc_wr, 1'b0);
        chk("reset rdback", bus.CTRL_RD_VALUE, 8'h00);
        chk("reset sel_wp", sel_wp, 1'b1);
        chk("reset sel_ready", sel_ready, 1'b0);
        bus.FDC_WR_REQ = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (8) @(negedge CLK);
        chk("post-reset idle", {fdc_rd, fdc_wr}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fdc_drive_ctrl.md
Name: fdc_drive_ctrl

Overview:
- Parametrised floppy-drive front-end that sits between the CoCo CPU bus and a single wd1793 core.
- Decodes the drive-control register and generalises drive selection to NUM_DRIVES drives.
- Stretches CPU read/write strobes onto the FDC clock enable through a one-deep request queue.
- Captures per-drive mount metadata, routes SD block requests to the selected drive with a per-transfer lock, and adds a motor-off timeout.

Parameters:
- NUM_DRIVES, 3: drives supported, legal range 1..3.
- CE_DIV, 6: CLK cycles per fdc_ce pulse, legal range 2..63.
- MOTOR_TO, 16666666: fdc_ce pulses before the motor auto-stops; 25-bit counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- CPU_DATA_IN  in  8  CPU write data.
- CPU_ADDR  in  2  FDC register address.
- CTRL_WR  in  1  one-cycle write strobe to the drive-control register.
- CTRL_RD_VALUE  out  8  readback of the control register.
- FDC_RD_REQ  in  1  level, CPU reading FDC registers (async to CLK).
- FDC_WR_REQ  in  1  level, CPU writing FDC registers (async to CLK).
- fdc_ce  out  1  FDC clock enable.
- fdc_rd  out  1  stretched FDC read strobe.
- fdc_wr  out  1  stretched FDC write strobe.
- fdc_addr  out  2  latched register address.
- fdc_din  out  8  latched write data.
- fdc_drq  in  1  wd1793 DRQ.
- fdc_intrq  in  1  wd1793 INTRQ.
- HALT  out  1  CPU halt request.
- NMI  out  1  CPU NMI.
- drive_index  out  2  selected drive, 1..NUM_DRIVES; 0 = none.
- motor_on  out  1  motor state.
- img_mounted  in  NUM_DRIVES  mount strobes, one per drive.
- img_readonly  in  1  write-protect flag for the mounting drive.
- img_size  in  64  image size in bytes.
- sel_wp  out  1  selected drive write protect.
- sel_ready  out  1  selected drive ready.
- sel_ds  out  1  selected drive double-sided.
- sel_side  out  1  side to FDC.
- sel_size  out  20  selected drive image size.
- fdc_sd_rd  in  1  SD read request from the FDC.
- fdc_sd_wr  in  1  SD write request from the FDC.
- fdc_sd_ack  out  1  SD ack returned to the FDC.
- sd_rd  out  NUM_DRIVES  per-drive SD read request.
- sd_wr  out  NUM_DRIVES  per-drive SD write request.
- sd_ack  in  NUM_DRIVES  per-drive SD ack.

Behaviour:
- Reset: all registers and outputs 0, except per-drive wp=1. This gives CTRL_RD_VALUE=00, drive_index=0, HALT=0, NMI=0, motor_on=0, sel_ready=0.
- CE divider:
  - Counts 0..CE_DIV-1.
  - fdc_ce=1 during count CE_DIV-1, then the counter wraps to 0.
- Control register, written on CTRL_WR:
  - Bit 7 halt_en, bit 6 side, bit 5 density, bit 4 precomp, bit 3 motor, bits 2:0 drive-select one-hot.
  - CTRL_RD_VALUE returns the stored bits, with bit 7 = current halt_en.
- drive_index:
  - Set to the lowest set bit among bits 2:0, plus 1.
  - Becomes 0 if no bit is set or the resulting index exceeds NUM_DRIVES.
- halt_en:
  - Cleared in any cycle where fdc_intrq=1; this has priority over a simultaneous CTRL_WR.
  - HALT = halt_en & ~fdc_drq.
  - NMI = density & fdc_intrq.
- Access FSM, states IDLE, ARMED, HOLD:
  - FDC_RD_REQ and FDC_WR_REQ each pass through a 2-flop synchronizer.
  - On the first-flop rising edge, CPU_ADDR and CPU_DATA_IN are captured into a pending slot.
  - IDLE -> ARMED when a pending edge exists; fdc_rd or fdc_wr is asserted and fdc_addr/fdc_din are loaded from the slot.
  - ARMED -> HOLD in a cycle with fdc_ce=1.
  - HOLD -> IDLE after one cycle, with the strobe deasserted. Strobes therefore always overlap exactly one fdc_ce.
  - An edge arriving while not IDLE fills the single pending slot and is serviced on return to IDLE; a second edge overwrites the slot.
  - Simultaneous read and write edges: the write wins.
- Motor:
  - CTRL_WR with bit 3=1 sets motor_on and reloads the counter to MOTOR_TO.
  - Entering ARMED also reloads the counter when motor_on=1.
  - Each fdc_ce decrements the counter; reaching 0 clears motor_on.
  - CTRL_WR with bit 3=0 clears motor_on immediately.
  - Reload in the same cycle as the terminal decrement wins.
- Mount capture, per drive i:
  - A registered falling-edge detect on img_mounted[i] captures wp_i=img_readonly, size_i=img_size[19:0], ready_i=1.
  - ds_i=1 when 368600 < img_size < 740000.
- Selected outputs, with drive_index=0 defaulting to drive 1:
  - sel_wp, sel_ds and sel_size come from the selected drive.
  - sel_ready = ready & motor_on.
  - sel_side = sel_ds & side.
- SD routing:
  - When fdc_sd_rd or fdc_sd_wr rises with drive_index!=0, the index is locked.
  - Requests and ack route only to the locked drive until the locked sd_ack falls.
  - A drive change mid-transfer has no effect until the unlock.
  - Requests with drive_index=0 are never forwarded and fdc_sd_ack stays 0.
- Reset mid-operation: the FSM returns to IDLE, the pending slot and lock clear, and strobes drop asynchronously.

Optional Feature:
- Macro FDC_MOTOR_TIMEOUT_EN.
- Defined: the timeout counter is present as described above.
- Undefined: no counter; motor_on simply mirrors register bit 3, and sel_ready = ready of the selected drive.

Test Plan:
- Reset, then CTRL_WR 0x8A -> drive_index=2, motor_on=1, HALT=1 while fdc_drq=0; CTRL_RD_VALUE=0x8A; fdc_intrq pulse -> HALT=0, CTRL_RD_VALUE=0x0A.
- CTRL_WR 0x07 -> drive_index=1; with NUM_DRIVES=2, CTRL_WR 0x04 -> drive_index=0 and fdc_sd_rd not forwarded.
- FDC_WR_REQ with addr=3, data=0x5A, plus an FDC_RD_REQ edge 2 cycles later -> fdc_wr with fdc_addr=3/fdc_din=0x5A across exactly one fdc_ce, then fdc_rd issued after return to IDLE.
- Mount drive 2 with size 368640 and readonly=1 -> select drive 2 with side=1: sel_ds=1, sel_side=1, sel_wp=1, sel_size=368640.
- Lock drive 1, fdc_sd_rd=1; switch to drive 2 before sd_ack[0] falls -> sd_rd stays 2'b01 until ack falls.
- MOTOR_TO=10 with macro defined -> motor_on clears after 10 fdc_ce pulses; an FDC access at pulse 9 reloads the counter.
